// File: rtl/muller_pipe_c.sv
// muller_pipe_c
//   Clocked emulation of a Muller C-element micropipeline: DEPTH C-element
//   stages in a chain, each with a WIDTH-bit bundled-data latch. Both ends use
//   a four-phase req/ack handshake. The producer side is monitored for
//   protocol violations, which raise a sticky err flag.
//
// Parameters
//   WIDTH    data bits per stage (1..64)
//   DEPTH    number of C-element stages (2..32)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears state, data and err)
//   hold      (only with MULLER_PIPE_HOLD_EN) freezes all state while high
//   in_req    producer request
//   in_ack    acknowledge to producer (= first stage C-element)
//   in_data   bundled data, stable while in_req is high
//   out_req   request to consumer (= last stage C-element)
//   out_ack   consumer acknowledge
//   out_data  last-stage latch contents
//   busy      any stage C-element is 1
//   err       sticky producer-protocol violation
//
// Configuration macro
//   MULLER_PIPE_HOLD_EN  adds the hold input; undefined = no hold port.

module muller_pipe_c #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
`ifdef MULLER_PIPE_HOLD_EN
   input  logic             hold,
`endif
   input  logic             in_req,
   output logic             in_ack,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_req,
   input  logic             out_ack,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             err
);

   // C-element outputs and per-stage data latches
   logic [DEPTH-1:0]            r_c;
   logic [DEPTH-1:0][WIDTH-1:0] r_d;
   logic                        r_err;

   // previous-sample copies used only by the protocol checker
   logic                        r_req_q;
   logic                        r_ack_q;
   logic [WIDTH-1:0]            r_data_q;

   logic [DEPTH-1:0]            w_left;
   logic [DEPTH-1:0]            w_right;
   logic [DEPTH-1:0]            w_c_nxt;
   logic [DEPTH-1:0]            w_rise;
   logic [DEPTH-1:0][WIDTH-1:0] w_src;
   logic                        w_adv;
   logic                        w_viol;

`ifdef MULLER_PIPE_HOLD_EN
   assign w_adv = ~hold;
`else
   assign w_adv = 1'b1;
`endif

   // Neighbour vectors: stage i sees c[i-1] on the left (in_req for stage 0)
   // and c[i+1] on the right (out_ack for the last stage).
   assign w_left  = {r_c[DEPTH-2:0], in_req};
   assign w_right = {out_ack, r_c[DEPTH-1:1]};

   // C-element as a majority function of (a1, a2, c) with a2 = ~right:
   // both inputs high -> 1, both low -> 0, otherwise hold.
   assign w_c_nxt = (w_left & ~w_right) | (r_c & (w_left | ~w_right));
   assign w_rise  = w_c_nxt & ~r_c;

   // Data source per stage: producer data for stage 0, previous latch otherwise
   assign w_src = {r_d[DEPTH-2:0], in_data};

   // Violation 1: in_req moved while the previous sample showed a handshake
   //              still in flight (previous in_req != previous in_ack).
   // Violation 2: in_data moved while a request is held and not yet acked.
   //              r_req_q is required so data may change together with the
   //              rising edge of in_req.
   assign w_viol = ((in_req != r_req_q) && (r_req_q != r_ack_q)) ||
                   (in_req && r_req_q && !r_c[0] && (in_data != r_data_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c      <= '0;
         r_d      <= '0;
         r_err    <= 1'b0;
         r_req_q  <= 1'b0;
         r_ack_q  <= 1'b0;
         r_data_q <= '0;
      end else if (w_adv) begin
         r_c <= w_c_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            if (w_rise[i]) r_d[i] <= w_src[i];
         end
         r_req_q  <= in_req;
         r_ack_q  <= r_c[0];
         r_data_q <= in_data;
         if (w_viol) r_err <= 1'b1;
      end
   end

   assign in_ack   = r_c[0];
   assign out_req  = r_c[DEPTH-1];
   assign out_data = r_d[DEPTH-1];
   assign busy     = |r_c;
   assign err      = r_err;

endmodule

// File: doc/muller_pipe_c.md
Name: muller_pipe_c

Overview:
- Parametrised, clocked emulation of a Muller C-element micropipeline: a chain of DEPTH two-input C-elements with WIDTH-bit bundled-data latches.
- Uses a four-phase handshake on input and output.
- Successor to the single-bit C-element cells. Adds depth, data width, synchronous clear and handshake-protocol checking.
- Sits between an asynchronous-style producer and consumer in synchronous test and prototyping builds.

Parameters:
- WIDTH, 8, data bits per stage (1..64)
- DEPTH, 4, number of C-element stages (2..32)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_req  input  1  producer request (four-phase)
- in_ack  output  1  acknowledge to producer
- in_data  input  WIDTH  bundled data; must be stable while in_req is high
- out_req  output  1  request to consumer
- out_ack  input  1  consumer acknowledge (four-phase)
- out_data  output  WIDTH  bundled data; valid while out_req is high
- busy  output  1  high when any stage C-element state is 1
- err  output  1  sticky input-protocol violation flag

Behaviour:
- State: c[0..DEPTH-1] (C-element outputs) and d[0..DEPTH-1] (WIDTH-bit latches).
- Boundaries: left(0) = in_req, right(DEPTH-1) = out_ack.
- Stage inputs: a1 = left neighbour c[i-1], a2 = NOT right neighbour c[i+1].
- C-element rule per clock, all stages updated in parallel from previous-cycle values:
  - a1 = a2 = 1: c[i] <= 1
  - a1 = a2 = 0: c[i] <= 0
  - otherwise: c[i] holds
- Data capture: d[i] <= (i==0 ? in_data : d[i-1]) only on a cycle where c[i] goes 0->1; otherwise d[i] holds.
- Output mapping: in_ack = c[0]; out_req = c[DEPTH-1]; out_data = d[DEPTH-1]; busy = OR of c[].
- Latency:
  - in_req rise to in_ack rise: 1 cycle.
  - in_req rise to out_req rise on an empty pipe: DEPTH cycles.
  - Each wavefront advances one stage per cycle.
- Capacity: at most ceil(DEPTH/2) tokens resident. The stage ahead of each token must be a bubble. A full pipe holds in_ack low after in_req rises until space propagates back.
- Order: tokens are delivered in arrival order. None are dropped or duplicated while the protocol is obeyed.
- Reset (rst=1 at an edge), taking effect that edge regardless of handshake phase:
  - c[] = 0, d[] = 0, err = 0
  - hence in_ack = 0, out_req = 0, out_data = 0, busy = 0
- Reset mid-transfer: all tokens are discarded. The producer must return in_req to 0 before the next request; the first post-reset in_req=1 is treated as a new token.
- err is set (sticky until rst) when either violation occurs:
  - in_req changes on a cycle where the previous-cycle in_req != previous-cycle in_ack (request withdrawn or re-raised before acknowledge).
  - in_data changes while in_req=1 and in_ack=0.
- err does not alter pipeline behaviour.
- The consumer side is not checked.
- Simultaneous events: a stage whose neighbours change on the same cycle evaluates using previous-cycle neighbour values only; no combinational path from in_req or out_ack to any output.
- out_ack held 1 with out_req 0 is a stall-free idle state; c[DEPTH-1] cannot rise until out_ack returns to 0.

Optional Feature:
- Macro: MULLER_PIPE_HOLD_EN.
- Defined:
  - Adds input port hold (1 bit) after rst.
  - While hold=1, c[], d[] and err are frozen (no C-element evaluation, no capture, no error check); outputs keep their values.
  - rst takes priority over hold.
- Undefined: port hold is absent; every stage evaluates every cycle.

Test Plan:
- Reset, WIDTH=8, DEPTH=4: assert rst 2 cycles -> in_ack=0, out_req=0, out_data=0x00, busy=0, err=0 on the cycle after release.
- Single token, DEPTH=4: in_data=0xA5, in_req=1 at cycle 0, out_ack follows out_req after 1 cycle -> in_ack=1 at cycle 1, out_req=1 at cycle 4, out_data=0xA5; full four-phase return leaves busy=0.
- Stream with out_ack tied to a responsive consumer: 6 tokens 0x01..0x06 -> received in order 0x01..0x06, err=0.
- Backpressure: out_ack stuck at 1 then 0 with no further responses, DEPTH=4, 4 tokens offered -> at most 2 tokens accepted, in_ack stays low for the third, no data lost after out_ack resumes.
- Protocol violation: in_req 1 then 0 on the next cycle before in_ack=1 -> err=1 next cycle and stays 1 until rst.
- Reset mid-operation with 2 tokens resident -> all c[]=0 next cycle and out_req=0; with MULLER_PIPE_HOLD_EN, hold=1 for 5 cycles during a transfer -> outputs unchanged, transfer completes after hold is released.
